// File: rtl/writeback_commit_buffer_pkg.sv
// Shared types and helpers for the dual-issue writeback commit buffer.
package writeback_commit_buffer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_slot_t;

  typedef struct packed {
    wb_slot_t s1;
    wb_slot_t s2;
  } wb_pair_t;

  // Drop $zero writes; on a same-address pair only the younger slot 2 survives.
  function automatic wb_pair_t sanitise_pair(input wb_pair_t p);
    wb_pair_t r;
    r = p;
    r.s1.we = p.s1.we && (p.s1.addr != REG_ZERO);
    r.s2.we = p.s2.we && (p.s2.addr != REG_ZERO);
    if (r.s1.we && r.s2.we && (p.s1.addr == p.s2.addr)) begin
      r.s1.we = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_pair_fifo.sv
// In-order FIFO of result pairs; exposes every entry with a valid bit so the
// top level can search for pending register writes.
module wb_pair_fifo
  import writeback_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  wb_pair_t                 push_pair_i,
  input  logic                     pop_i,
  output wb_pair_t                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_pair_t                 entries_o [DEPTH],
  output logic [DEPTH-1:0]         valid_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  wb_pair_t      mem_q [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_pair_i;
    end
  end

  // Entry e is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] offset;
    valid_o = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      offset     = PW'(e) - rd_ptr_q;
      valid_o[e] = CW'(offset) < count_q;
    end
  end

  assign entries_o = mem_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/writeback_commit_buffer.sv
// Dual-issue writeback stage: sanitises result pairs, buffers them in order and
// commits one pair per cycle onto the two register-file write ports.
module writeback_commit_buffer
  import writeback_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_we_1,
  input  logic [ADDR_W-1:0]      in_addr_1,
  input  logic [DATA_W-1:0]      in_data_1,
  input  logic                   in_we_2,
  input  logic [ADDR_W-1:0]      in_addr_2,
  input  logic [DATA_W-1:0]      in_data_2,
  input  logic                   hold,
  input  logic                   flush,
  output logic                   Write_Enable_1,
  output logic [ADDR_W-1:0]      Write_Addr_1,
  output logic [DATA_W-1:0]      Write_Data_1,
  output logic                   Write_Enable_2,
  output logic [ADDR_W-1:0]      Write_Addr_2,
  output logic [DATA_W-1:0]      Write_Data_2,
  input  logic [4*ADDR_W-1:0]    query_addr,
  output logic [3:0]             query_pending,
  output logic [$clog2(DEPTH):0] occupancy
);

  wb_pair_t         in_pair, push_pair, head;
  wb_pair_t         entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic             full, empty, push, pop;
  wb_slot_t         port1_q, port1_d, port2_q, port2_d;

  assign in_pair.s1 = '{we: in_we_1, addr: in_addr_1, data: in_data_1};
  assign in_pair.s2 = '{we: in_we_2, addr: in_addr_2, data: in_data_2};
  assign push_pair  = sanitise_pair(in_pair);

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !flush && !hold && !empty;

  wb_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (flush),
    .push_i      (push),
    .push_pair_i (push_pair),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (occupancy),
    .entries_o   (entries),
    .valid_o     (entry_valid)
  );

  // Enables drop whenever nothing is popped; address/data keep their last value.
  always_comb begin
    port1_d    = port1_q;
    port2_d    = port2_q;
    port1_d.we = 1'b0;
    port2_d.we = 1'b0;
    if (pop) begin
      port1_d = head.s1;
      port2_d = head.s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port1_q <= '0;
      port2_q <= '0;
    end else begin
      port1_q <= port1_d;
      port2_q <= port2_d;
    end
  end

  assign Write_Enable_1 = port1_q.we;
  assign Write_Addr_1   = port1_q.addr;
  assign Write_Data_1   = port1_q.data;
  assign Write_Enable_2 = port2_q.we;
  assign Write_Addr_2   = port2_q.addr;
  assign Write_Data_2   = port2_q.data;

  always_comb begin
    logic [ADDR_W-1:0] qa;
    query_pending = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      qa = query_addr[i*ADDR_W +: ADDR_W];
      if (qa != REG_ZERO) begin
        if ((port1_q.we && port1_q.addr == qa) || (port2_q.we && port2_q.addr == qa)) begin
          query_pending[i] = 1'b1;
        end
        for (int unsigned e = 0; e < DEPTH; e++) begin
          if (entry_valid[e] &&
              ((entries[e].s1.we && entries[e].s1.addr == qa) ||
               (entries[e].s2.we && entries[e].s2.addr == qa))) begin
            query_pending[i] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_commit_buffer.sv
// Directed and randomized bench for writeback_commit_buffer against a queue-based model.
module tb_writeback_commit_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_we_1 = 1'b0, in_we_2 = 1'b0;
  logic [4:0]  in_addr_1 = '0, in_addr_2 = '0;
  logic [31:0] in_data_1 = '0, in_data_2 = '0;
  logic        hold = 1'b0, flush = 1'b0;
  logic        Write_Enable_1, Write_Enable_2;
  logic [4:0]  Write_Addr_1, Write_Addr_2;
  logic [31:0] Write_Data_1, Write_Data_2;
  logic [19:0] query_addr = '0;
  logic [3:0]  query_pending;
  logic [2:0]  occupancy;

  writeback_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_we_1(in_we_1), .in_addr_1(in_addr_1), .in_data_1(in_data_1),
    .in_we_2(in_we_2), .in_addr_2(in_addr_2), .in_data_2(in_data_2),
    .hold(hold), .flush(flush),
    .Write_Enable_1(Write_Enable_1), .Write_Addr_1(Write_Addr_1), .Write_Data_1(Write_Data_1),
    .Write_Enable_2(Write_Enable_2), .Write_Addr_2(Write_Addr_2), .Write_Data_2(Write_Data_2),
    .query_addr(query_addr), .query_pending(query_pending), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          we2;
    logic [4:0]  a2;
    logic [31:0] d2;
  } mpair_t;

  mpair_t      model_q[$];
  bit          m_we1 = 0, m_we2 = 0;
  logic [4:0]  m_a1 = '0, m_a2 = '0;
  logic [31:0] m_d1 = '0, m_d2 = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_pending();
    logic [3:0] r;
    logic [4:0] qa;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      qa = query_addr[i*5 +: 5];
      if (qa != 0) begin
        if ((m_we1 && m_a1 == qa) || (m_we2 && m_a2 == qa)) r[i] = 1'b1;
        foreach (model_q[k])
          if ((model_q[k].we1 && model_q[k].a1 == qa) || (model_q[k].we2 && model_q[k].a2 == qa))
            r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    chk("occupancy", 32'(occupancy), 32'(model_q.size()));
    chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
    chk("we1", 32'(Write_Enable_1), 32'(m_we1));
    chk("addr1", 32'(Write_Addr_1), 32'(m_a1));
    chk("data1", Write_Data_1, m_d1);
    chk("we2", 32'(Write_Enable_2), 32'(m_we2));
    chk("addr2", 32'(Write_Addr_2), 32'(m_a2));
    chk("data2", Write_Data_2, m_d2);
    chk("pending", 32'(query_pending), 32'(model_pending()));
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, then check.
  task automatic tick();
    mpair_t p, e;
    bit acc;
    p.we1 = in_we_1 && (in_addr_1 != 0);
    p.we2 = in_we_2 && (in_addr_2 != 0);
    if (p.we1 && p.we2 && in_addr_1 == in_addr_2) p.we1 = 0;
    p.a1 = in_addr_1; p.d1 = in_data_1; p.a2 = in_addr_2; p.d2 = in_data_2;
    acc = in_valid && (model_q.size() < DEPTH);
    @(posedge clk);
    if (flush) begin
      model_q.delete();
      m_we1 = 0; m_we2 = 0;
    end else begin
      if (!hold && model_q.size() > 0) begin
        e = model_q.pop_front();
        m_we1 = e.we1; m_a1 = e.a1; m_d1 = e.d1;
        m_we2 = e.we2; m_a2 = e.a2; m_d2 = e.d2;
      end else begin
        m_we1 = 0; m_we2 = 0;
      end
      if (acc) model_q.push_back(p);
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic w2, input logic [4:0] a2, input logic [31:0] d2);
    in_valid = v;
    in_we_1 = w1; in_addr_1 = a1; in_data_1 = d1;
    in_we_2 = w2; in_addr_2 = a2; in_data_2 = d2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_we1", 32'(Write_Enable_1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();

    // Single write
    drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("single_we1", 32'(Write_Enable_1), 32'd1);
    chk("single_addr1", 32'(Write_Addr_1), 32'd5);
    chk("single_data1", Write_Data_1, 32'hDEADBEEF);
    chk("single_we2", 32'(Write_Enable_2), 32'd0);

    // Same-address collision: younger wins
    drive(1, 1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("coll_we1", 32'(Write_Enable_1), 32'd0);
    chk("coll_we2", 32'(Write_Enable_2), 32'd1);
    chk("coll_data2", Write_Data_2, 32'h2);

    // $zero write dropped
    drive(1, 1, 5'd0, 32'h55, 0, 5'd0, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("zero_we1", 32'(Write_Enable_1), 32'd0);

    // Full / backpressure
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i));
      tick();
    end
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    drive(1, 1, 5'd30, 32'hBAD, 0, 0, 0);
    tick();
    chk("full_fifth_ignored", 32'(occupancy), 32'd4);
    hold = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("drain_ready", 32'(in_ready), 32'd1);
    chk("drain_first", 32'(Write_Addr_1), 32'd10);
    repeat (4) tick();

    // Pending query on r9
    query_addr = {5'd0, 5'd0, 5'd0, 5'd9};
    drive(1, 1, 5'd9, 32'h99, 0, 0, 0);
    tick();
    chk("pend_fifo", 32'(query_pending), 32'b0001);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pend_outstage", 32'(query_pending), 32'b0001);
    tick();
    chk("pend_clear", 32'(query_pending), 32'b0000);
    query_addr = '0;

    // Flush with occupancy 3 and a simultaneous new pair
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(3 + i), 32'(i), 0, 0, 0);
      tick();
    end
    hold = 0; flush = 1;
    drive(1, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13);
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_we1", 32'(Write_Enable_1), 32'd0);
    chk("flush_we2", 32'(Write_Enable_2), 32'd0);
    tick();

    // Async reset mid-stream
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(16 + i), 32'(16 + i), 1, 5'(24 + i), 32'(24 + i));
      tick();
    end
    hold = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("pre_reset_occ", 32'(occupancy), 32'd2);
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    m_we1 = 0; m_we2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
    chk("async_occ", 32'(occupancy), 32'd0);
    chk("async_we1", 32'(Write_Enable_1), 32'd0);
    chk("async_we2", 32'(Write_Enable_2), 32'd0);
    reset = 1'b1;
    drive(1, 1, 5'd11, 32'hCAFE, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_reset_we1", 32'(Write_Enable_1), 32'd1);
    chk("post_reset_data1", Write_Data_1, 32'hCAFE);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      hold = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 24) == 0);
      query_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_commit_buffer.md
Name: writeback_commit_buffer

Overview:
Dual-issue writeback stage that drives the two write ports of the 32x32 register file.
- Accepts one result pair per cycle (slot 1 = older, slot 2 = younger) from the memory stage over a valid/ready handshake.
- Buffers pairs in a small in-order FIFO and commits one pair per cycle onto the register-file write ports.
- Resolves same-address conflicts and drops $zero writes before they reach the register file.
- Reports which register reads are still pending so the issue stage can stall.

Parameters:
DEPTH, 4, FIFO entries (result pairs); power of two, >=2
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  result pair presented
in_ready  out  1  buffer can accept; = !full
in_we_1  in  1  slot-1 write request
in_addr_1  in  ADDR_W  slot-1 destination
in_data_1  in  DATA_W  slot-1 result
in_we_2  in  1  slot-2 write request
in_addr_2  in  ADDR_W  slot-2 destination
in_data_2  in  DATA_W  slot-2 result
hold  in  1  suppress commits this cycle (debug/exception)
flush  in  1  synchronous discard of all buffered and output-stage writes
Write_Enable_1  out  1  register-file port 1 enable (registered)
Write_Addr_1  out  ADDR_W  port 1 address (registered)
Write_Data_1  out  DATA_W  port 1 data (registered)
Write_Enable_2  out  1  port 2 enable (registered)
Write_Addr_2  out  ADDR_W  port 2 address (registered)
Write_Data_2  out  DATA_W  port 2 data (registered)
query_addr  in  4*ADDR_W  RS1,RT1,RS2,RT2 addresses of the issuing pair, packed [4:1] high to low
query_pending  out  4  bit i=1: an uncommitted write targets query address i
occupancy  out  clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (reset=0, async): rd/wr pointers=0; count=0; all Write_* outputs=0; in_ready=1 after release.
- Enqueue fires when in_valid && in_ready && !flush. No pass-through when full; in_ready depends on count only.
- Enqueue sanitising, per slot: we' = we && (addr != 0). If we_1' && we_2' && addr_1 == addr_2, force slot-1 we'=0 (younger wins).
- Stored addr/data are kept as presented, even when the write enable is dropped.
- Commit, each edge with !flush:
  - If !hold and count>0: pop head into the Write_* registers.
  - Otherwise: Write_Enable_1/2 <= 0. Addr/data registers hold their previous values.
- Latency, empty buffer: pair accepted at edge k -> Write_* valid after edge k+1 -> register file captures at edge k+2. Throughput is one pair per cycle.
- Simultaneous enqueue and pop: count unchanged. Legal only when not full on entry.
- Flush: next edge sets count=0, pointers=0, Write_Enable_1/2=0. Flush beats enqueue and commit in the same cycle.
- hold mid-stream: entries retained. Commits resume in order on the first edge with hold=0.
- query_pending[i] is combinational. It is 1 iff query address i != 0 and it matches the address of any sanitised enable in either:
  - a valid FIFO entry, or
  - the output register stage (not yet captured by the register file).
- occupancy = count. Pointer wrap is modulo DEPTH. Full when count == DEPTH.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=0
  - typedef wb_slot_t {we, addr, data}
  - typedef wb_pair_t {wb_slot_t s1, s2}
- One sub-module, wb_pair_fifo: DEPTH x wb_pair_t storage with pointers, count, full/empty and a flush port. It exposes all entries plus valid bits for the pending compare.
- Sanitising, commit registers and pending logic stay in the top level.

Test Plan:
- Single write: pair {we1=1,a1=5,d1=0xDEADBEEF; we2=0} at edge k -> Write_Enable_1=1, Write_Addr_1=5, Write_Data_1=0xDEADBEEF after edge k+1; Write_Enable_2=0.
- Collision and $zero: {we1=1,a1=7,d1=0x1; we2=1,a2=7,d2=0x2} -> only port 2 enabled (addr 7, data 0x2). {we1=1,a1=0} -> Write_Enable_1=0.
- Full/backpressure: hold=1, push 4 pairs -> occupancy=4, in_ready=0; 5th pair is ignored. Release hold -> 4 commits in order on consecutive cycles, in_ready=1 after the first pop.
- Pending: buffer a write to r9, query_addr RS1=9 -> query_pending[0]=1, other bits 0. Bit 0 stays 1 while the entry is in the output stage and clears the cycle after it commits.
- Flush with hold=0, occupancy=3, in_valid=1 on the same cycle -> after the edge occupancy=0, both enables 0, the new pair is dropped.
- Async reset mid-stream: drop reset between edges while occupancy=2 -> Write_Enable_* and occupancy go to 0 immediately without a clock edge; after release the first new pair commits with normal latency.
